// File: rtl/cartoon_pkg.sv
// Shared constants and types for the cartoon filter output path.
// The burst length and pixel stride are also used by the pixel buffer datapath.
package cartoon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } wsched_state_t;

    localparam int CARTOON_FRAME_W      = 640;
    localparam int CARTOON_FRAME_H      = 480;
    localparam int CARTOON_FRAME_PIXELS = CARTOON_FRAME_W * CARTOON_FRAME_H;
    localparam int CARTOON_BURST_LEN    = 6;
    localparam int CARTOON_PIX_STRIDE   = 4;

endpackage

// File: rtl/flex_counter.sv
// Modulo-ROLLOVER event counter.
// at_last_o flags the count on which the next enabled event wraps back to zero.
module flex_counter #(
    parameter int WIDTH    = 3,
    parameter int ROLLOVER = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic count_en_i,
    output logic at_last_o
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(ROLLOVER - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_en_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign at_last_o = (count_q == LAST);

endmodule

// File: rtl/write_sched.sv
// Ping-pong write buffer sequencer: fills one BURST_LEN-pixel bank from the filter
// while the other drains to SDRAM through an Avalon-MM write master.
module write_sched
    import cartoon_pkg::*;
#(
    parameter int                BURST_LEN    = CARTOON_BURST_LEN,
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
    parameter int                PIX_STRIDE   = CARTOON_PIX_STRIDE,
    parameter int                FRAME_PIXELS = CARTOON_FRAME_PIXELS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pixel_valid,
    output logic              pixel_ready,
    output logic              buf_load,
    output logic              fill_sel,
    output logic              buf_shift,
    output logic              drain_sel,
    output logic              master_write,
    output logic [ADDR_W-1:0] master_address,
    input  logic              master_waitrequest,
    output logic              busy,
    output logic              frame_done,
    output wsched_state_t     dbg_state
);

    localparam int                CNT_W     = $clog2(FRAME_PIXELS + 1);
    localparam int                BL_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0]  FRAME_CNT = CNT_W'(FRAME_PIXELS);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(FRAME_PIXELS - 1);
    localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(PIX_STRIDE);

    if (FRAME_PIXELS % BURST_LEN != 0) begin : g_bad_frame_size
        $error("write_sched: FRAME_PIXELS must be a multiple of BURST_LEN");
    end

    wsched_state_t     state_q, state_d;
    logic [1:0]        bank_full_q, bank_full_d;
    logic              fill_sel_q, fill_sel_d;
    logic              drain_sel_q, drain_sel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  accepted_cnt_q, accepted_cnt_d;
    logic [CNT_W-1:0]  written_cnt_q, written_cnt_d;

    logic run, xfer, wr_acc, fill_at_last, drain_at_last, clear_cnt;

    // Handshakes: a pixel moves when pixel_valid && pixel_ready; a write is taken
    // when master_write && !master_waitrequest. Both ready/write depend only on
    // registered state, so neither side sees a combinational path from its own input.
    assign run          = (state_q == RUN);
    assign pixel_ready  = run && !bank_full_q[fill_sel_q] && (accepted_cnt_q < FRAME_CNT);
    assign xfer         = pixel_valid && pixel_ready;
    assign master_write = run && bank_full_q[drain_sel_q];
    assign wr_acc       = master_write && !master_waitrequest;
    assign clear_cnt    = (state_q == DONE);

    flex_counter #(.WIDTH(BL_W), .ROLLOVER(BURST_LEN)) u_fill_cnt (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (clear_cnt),
        .count_en_i (xfer),
        .at_last_o  (fill_at_last)
    );

    flex_counter #(.WIDTH(BL_W), .ROLLOVER(BURST_LEN)) u_drain_cnt (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (clear_cnt),
        .count_en_i (wr_acc),
        .at_last_o  (drain_at_last)
    );

    always_comb begin
        state_d        = state_q;
        bank_full_d    = bank_full_q;
        fill_sel_d     = fill_sel_q;
        drain_sel_d    = drain_sel_q;
        addr_d         = addr_q;
        accepted_cnt_d = accepted_cnt_q;
        written_cnt_d  = written_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                // Fill and drain always target different banks, so both updates can land together.
                if (xfer) begin
                    accepted_cnt_d = accepted_cnt_q + CNT_W'(1);
                    if (fill_at_last) begin
                        bank_full_d[fill_sel_q] = 1'b1;
                        fill_sel_d              = ~fill_sel_q;
                    end
                end
                if (wr_acc) begin
                    addr_d        = addr_q + STRIDE;
                    written_cnt_d = written_cnt_q + CNT_W'(1);
                    if (drain_at_last) begin
                        bank_full_d[drain_sel_q] = 1'b0;
                        drain_sel_d              = ~drain_sel_q;
                    end
                    if (written_cnt_q == LAST_CNT) state_d = DONE;
                end
            end
            DONE: begin
                state_d        = IDLE;
                bank_full_d    = 2'b00;
                fill_sel_d     = 1'b0;
                drain_sel_d    = 1'b0;
                addr_d         = BASE_ADDR;
                accepted_cnt_d = '0;
                written_cnt_d  = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            bank_full_q    <= 2'b00;
            fill_sel_q     <= 1'b0;
            drain_sel_q    <= 1'b0;
            addr_q         <= BASE_ADDR;
            accepted_cnt_q <= '0;
            written_cnt_q  <= '0;
        end else begin
            state_q        <= state_d;
            bank_full_q    <= bank_full_d;
            fill_sel_q     <= fill_sel_d;
            drain_sel_q    <= drain_sel_d;
            addr_q         <= addr_d;
            accepted_cnt_q <= accepted_cnt_d;
            written_cnt_q  <= written_cnt_d;
        end
    end

    assign buf_load       = xfer;
    assign buf_shift      = wr_acc;
    assign fill_sel       = fill_sel_q;
    assign drain_sel      = drain_sel_q;
    assign master_address = addr_q;
    assign busy           = (state_q != IDLE);
    assign frame_done     = (state_q == DONE);
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_write_sched.sv
// Bench for write_sched: a 24-pixel frame with 6-pixel banks, checked against a
// bank-occupancy model and an expected-address queue filled as pixels are accepted.
module tb_write_sched;

    localparam int             BL     = 6;
    localparam int             FP     = 24;
    localparam int             STRIDE = 4;
    localparam int             AW     = 32;
    localparam logic [AW-1:0]  BASE   = 32'h0000_1000;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          pixel_valid;
    logic          pixel_ready;
    logic          buf_load;
    logic          fill_sel;
    logic          buf_shift;
    logic          drain_sel;
    logic          master_write;
    logic [AW-1:0] master_address;
    logic          master_waitrequest;
    logic          busy;
    logic          frame_done;
    cartoon_pkg::wsched_state_t dbg_state;

    int tests = 0;
    int fails = 0;

    logic [AW-1:0] exp_q[$];
    int sent_n      = 0;
    int m_acc       = 0;
    int m_wr        = 0;
    int phase       = 0;    // 0 idle, 1 frame running, 2 frame-done cycle
    int seen_done   = 0;
    int addr8_cycles = 0;
    int wait_mode   = 0;    // 0 never stall, 1 always stall, 2 random, 3 stall at BASE+8
    int stall_left  = 0;
    bit abort_drv   = 1'b0;

    write_sched #(
        .BURST_LEN    (BL),
        .ADDR_W       (AW),
        .BASE_ADDR    (BASE),
        .PIX_STRIDE   (STRIDE),
        .FRAME_PIXELS (FP)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .pixel_valid        (pixel_valid),
        .pixel_ready        (pixel_ready),
        .buf_load           (buf_load),
        .fill_sel           (fill_sel),
        .buf_shift          (buf_shift),
        .drain_sel          (drain_sel),
        .master_write       (master_write),
        .master_address     (master_address),
        .master_waitrequest (master_waitrequest),
        .busy               (busy),
        .frame_done         (frame_done),
        .dbg_state          (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave stall generator
    initial begin
        master_waitrequest = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (wait_mode)
                1: master_waitrequest = 1'b1;
                2: master_waitrequest = ($urandom_range(0, 2) == 0);
                3: begin
                    if (master_write && master_address == BASE + 32'd8 && stall_left > 0) begin
                        master_waitrequest = 1'b1;
                        stall_left--;
                    end else begin
                        master_waitrequest = 1'b0;
                    end
                end
                default: master_waitrequest = 1'b0;
            endcase
        end
    end

    // Monitor: occupancy model in whole banks, plus address scoreboard
    initial begin
        int full_banks;
        logic exp_ready, exp_mw;
        int next_phase;
        cartoon_pkg::wsched_state_t exp_st;
        forever begin
            @(negedge clk);
            #1;
            next_phase = phase;
            if (rst) begin
                next_phase = 0;
                m_acc = 0;
                m_wr  = 0;
            end else begin
                if (frame_done) seen_done++;
                exp_st = (phase == 0) ? cartoon_pkg::IDLE :
                         (phase == 1) ? cartoon_pkg::RUN : cartoon_pkg::DONE;
                check("state", dbg_state, exp_st);
                if (phase == 0) begin
                    check("idle_ready", pixel_ready, 0);
                    check("idle_write", master_write, 0);
                    check("idle_busy", busy, 0);
                    check("idle_done", frame_done, 0);
                    check("idle_addr", master_address, BASE);
                    check("idle_sels", {fill_sel, drain_sel, buf_load, buf_shift}, 0);
                    if (start) next_phase = 1;
                end else if (phase == 1) begin
                    full_banks = m_acc / BL - m_wr / BL;
                    exp_ready  = (full_banks < 2) && (m_acc < FP);
                    exp_mw     = (full_banks > 0);
                    check("pixel_ready", pixel_ready, exp_ready);
                    check("master_write", master_write, exp_mw);
                    check("buf_load", buf_load, pixel_valid && exp_ready);
                    check("buf_shift", buf_shift, exp_mw && !master_waitrequest);
                    check("fill_sel", fill_sel, (m_acc / BL) % 2);
                    check("drain_sel", drain_sel, (m_wr / BL) % 2);
                    check("run_busy", busy, 1);
                    check("run_done", frame_done, 0);
                    if (pixel_valid && pixel_ready) m_acc++;
                    if (master_write) begin
                        if (master_address == BASE + 32'd8) addr8_cycles++;
                        if (exp_q.size() == 0) begin
                            check("write_without_pixel", exp_q.size(), 1);
                        end else begin
                            check("address", master_address, exp_q[0]);
                            if (!master_waitrequest) void'(exp_q.pop_front());
                        end
                        if (!master_waitrequest) begin
                            m_wr++;
                            if (m_wr == FP) next_phase = 2;
                        end
                    end
                end else begin
                    check("done_pulse", frame_done, 1);
                    check("done_busy", busy, 1);
                    check("done_write", master_write, 0);
                    check("done_ready", pixel_ready, 0);
                    m_acc = 0;
                    m_wr  = 0;
                    next_phase = 0;
                end
            end
            phase = next_phase;
        end
    end

    task automatic drive_pixels(input int n, input int gap_max);
        int budget = 3000;
        sent_n = 0;
        while (sent_n < n && !abort_drv && budget > 0) begin
            @(posedge clk);
            #1;
            pixel_valid = ($urandom_range(0, gap_max) == 0);
            @(negedge clk);
            if (pixel_valid && pixel_ready) begin
                exp_q.push_back(BASE + AW'(sent_n * STRIDE));
                sent_n++;
            end
            budget--;
        end
        @(posedge clk);
        #1;
        pixel_valid = 1'b0;
        if (budget == 0) check("drive_budget", sent_n, n);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int budget = 2000;
        while (phase != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        check(name, budget > 0, 1);
        check({name, "_queue"}, exp_q.size(), 0);
    endtask

    task automatic run_frame(input string name, input int gap_max);
        pulse_start();
        drive_pixels(FP, gap_max);
        wait_idle(name);
    endtask

    initial begin
        int hold;
        rst = 1'b1;
        start = 1'b0;
        pixel_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_ready", pixel_ready, 0);
        check("rst_write", master_write, 0);
        check("rst_addr", master_address, BASE);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        pixel_valid = 1'b0;
        repeat (3) @(posedge clk);

        run_frame("frame_basic", 0);

        wait_mode = 1;
        pulse_start();
        fork
            drive_pixels(FP, 0);
            begin
                repeat (40) @(posedge clk);
                #2;
                check("bp_accepts", sent_n, 2 * BL);
                check("bp_addr", master_address, BASE);
                check("bp_write", master_write, 1);
                wait_mode = 0;
            end
        join
        wait_idle("frame_backpressure");

        wait_mode = 2;
        run_frame("frame_rand_a", 2);
        run_frame("frame_rand_b", 3);
        wait_mode = 0;

        addr8_cycles = 0;
        stall_left = 3;
        wait_mode = 3;
        run_frame("frame_stall", 0);
        check("stall_addr8_cycles", addr8_cycles, 4);
        wait_mode = 0;

        pulse_start();
        fork
            drive_pixels(FP, 1);
            begin
                repeat (10) @(posedge clk);
                #1 start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
        join
        wait_idle("frame_start_in_run");

        pulse_start();
        fork
            drive_pixels(FP, 0);
            begin
                hold = 0;
                while (m_wr != 7 && hold < 300) begin
                    @(posedge clk);
                    #1;
                    hold++;
                end
                check("reach_wr7", m_wr, 7);
                rst = 1'b1;
                abort_drv = 1'b1;
            end
        join
        @(negedge clk);
        #1;
        check("midrst_write", master_write, 0);
        check("midrst_addr", master_address, BASE);
        check("midrst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        abort_drv = 1'b0;
        exp_q.delete();
        repeat (10) @(posedge clk);

        run_frame("frame_after_rst", 1);
        check("frame_done_count", seen_done, 7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/write_sched.md
Name: write_sched

Overview:
- Sequencing controller for the ping-pong pixel write buffer between the cartoon filter output and the Avalon-MM SDRAM write master.
- Tracks which of two BURST_LEN-pixel banks is filling and which is draining. Generates load/shift strobes for the buffer datapath.
- Issues Avalon write transactions with incrementing addresses, applies backpressure to the filter when both banks are full, and signals end of frame.

Parameters:
BURST_LEN, 6, pixels per bank; fill and drain unit
ADDR_W, 32, Avalon address width
BASE_ADDR, 32'h0000_0000, byte address of first output pixel
PIX_STRIDE, 4, byte increment per pixel word
FRAME_PIXELS, 307200, pixels per frame (640x480); must be a multiple of BURST_LEN (elaboration-time assertion)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse; begins a frame when idle
pixel_valid  in  1  filter presents a pixel this cycle
pixel_ready  out  1  controller accepts the pixel; a transfer occurs when valid&&ready
buf_load  out  1  load the pixel into the fill bank (= valid&&ready)
fill_sel  out  1  bank currently filling (0/1)
buf_shift  out  1  advance the drain bank by one pixel (= write accepted)
drain_sel  out  1  bank currently draining
master_write  out  1  Avalon write request
master_address  out  ADDR_W  Avalon byte address
master_waitrequest  in  1  Avalon stall
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse after the last pixel write is accepted

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high, sampled on the rising edge of clk. Reset overrides every other input.
- Reset values: state=IDLE; all outputs 0; master_address=BASE_ADDR; fill_sel=drain_sel=0; bank_full=2'b00; all counters 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start.
  - RUN -> DONE when a write is accepted and written_cnt reaches FRAME_PIXELS-1.
  - DONE -> IDLE unconditionally after 1 cycle. frame_done=1 only in DONE.
  - start outside IDLE is ignored.
- busy=1 in RUN and DONE.
- Fill side (RUN only):
  - pixel_ready = !bank_full[fill_sel] && (accepted_cnt < FRAME_PIXELS).
  - Each transfer increments fill_cnt. On the transfer with fill_cnt==BURST_LEN-1: set bank_full[fill_sel], clear fill_cnt, toggle fill_sel.
- Drain side (RUN only):
  - master_write = bank_full[drain_sel].
  - A write is accepted when master_write && !master_waitrequest. On acceptance: buf_shift=1 (same cycle), master_address += PIX_STRIDE, drain_cnt++, written_cnt++.
  - On the acceptance with drain_cnt==BURST_LEN-1: clear bank_full[drain_sel], clear drain_cnt, toggle drain_sel.
- Avalon rules: while master_waitrequest=1, master_write and master_address are held stable. master_write never drops mid-bank.
- Latency: the first master_write asserts in the cycle after the BURST_LEN-th pixel is accepted.
- Simultaneous events:
  - A fill completing on one bank and a drain completing on the other in the same cycle are both applied.
  - A bank cleared by the drain is fillable from the next cycle, not the same cycle.
- Both banks full: pixel_ready=0 until the drain bank empties.
- Counter widths: accepted_cnt and written_cnt are $clog2(FRAME_PIXELS+1) bits. master_address wraps modulo 2^ADDR_W.
- Leaving DONE: master_address reloads BASE_ADDR and the counters clear.
- rst mid-frame: abandons the frame, master_write=0 on the next cycle, no frame_done.

Decomposition:
- Shared package cartoon_pkg holds:
  - typedef enum {IDLE,RUN,DONE} wsched_state_t
  - constants for the default frame size (640x480)
  - BURST_LEN and PIX_STRIDE, shared with the buffer datapath
- One natural sub-module: the existing flex_counter, instanced twice, for fill_cnt and drain_cnt (rollover at BURST_LEN). Everything else stays in the top module.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, pixel_valid=1 -> pixel_ready=0, master_write=0, master_address=0, busy=0.
2. Basic frame, FRAME_PIXELS=12, BURST_LEN=6, no stall:
   - Stimulus: start, then 12 consecutive valid pixels.
   - Response: master_write rises the cycle after pixel 6. Addresses 0,4,...,44 appear once each. 12 buf_shift pulses. frame_done pulses once after the 12th accept; busy=0 the next cycle.
3. Backpressure:
   - Stimulus: master_waitrequest held 1 after start; drive 20 valid pixels.
   - Response: pixel_ready drops after 12 accepts. master_address stays 0 with master_write=1. Releasing waitrequest resumes accepts.
4. Stall mid-bank:
   - Stimulus: waitrequest=1 for 3 cycles at address 8.
   - Response: address 8 held for 4 cycles total. No extra buf_shift. drain_sel toggles only after address 20 is accepted.
5. Overlap: continuous pixels while draining -> fill of bank1 and drain of bank0 proceed together; bank toggles line up; no pixel lost or duplicated (scoreboard on 24 pixels).
6. Reset/start edge cases:
   - rst asserted at written_cnt=7: master_write=0 next cycle, no frame_done, address=BASE_ADDR.
   - start pulsed during RUN: no effect on counters.
